// File: rtl/lzc_pkg.sv
// lzc_pkg: shared constants and types for the 32-bit leading-zero counter.
//   LZC_WIDTH   - input word width (32)
//   LZC_ZW      - count width, wide enough to hold 32
//   LZC_BYTES   - number of byte lanes in the word
//   LZC_ALLZERO - count reported for an all-zero word
package lzc_pkg;

    localparam int unsigned LZC_WIDTH = 32;
    localparam int unsigned LZC_ZW    = 6;
    localparam int unsigned LZC_BYTES = 4;

    typedef logic [LZC_WIDTH-1:0] lzc_word_t;
    typedef logic [LZC_ZW-1:0]    lzc_cnt_t;

    localparam lzc_cnt_t LZC_ALLZERO = 6'd32;

endpackage

// File: rtl/lzc8.sv
// lzc8: combinational leading-zero count of one byte.
// Ports:
//   d    in  8  byte to count
//   cnt  out 3  leading zeros from bit 7; only meaningful when d != 0
//   zero out 1  d is all zeros
module lzc8 (
    input  logic [7:0] d,
    output logic [2:0] cnt,
    output logic       zero
);

    always_comb begin
        cnt  = 3'd0;
        zero = (d == 8'h00);
        // Ascending scan: the highest set bit is the last one to write cnt.
        for (int i = 0; i < 8; i++) begin
            if (d[i]) begin
                cnt = 3'(7 - i);
            end
        end
    end

endmodule

// File: rtl/lzc_top.sv
// lzc_top: 32-bit leading-zero counter with a single registered output stage.
// Ports:
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous active-low reset
//   in_valid  in  1      qualifies data this cycle
//   data      in  WIDTH  word to count
//   out_valid out 1      z holds a result from a valid input (in_valid delayed one cycle)
//   z         out ZW     leading-zero count, 0..32; holds while in_valid is low
module lzc_top
    import lzc_pkg::*;
#(
    parameter int unsigned WIDTH = LZC_WIDTH,
    parameter int unsigned ZW    = LZC_ZW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data,
    output logic             out_valid,
    output logic [ZW-1:0]    z
);

    logic [2:0]           byte_cnt  [LZC_BYTES];
    logic [LZC_BYTES-1:0] byte_zero;
    lzc_cnt_t             cnt_comb;

    logic [ZW-1:0] z_d, z_q;
    logic          out_valid_d, out_valid_q;

    for (genvar b = 0; b < LZC_BYTES; b++) begin : g_byte
        lzc8 u_lzc8 (
            .d    (data[8*b +: 8]),
            .cnt  (byte_cnt[b]),
            .zero (byte_zero[b])
        );
    end

    // Byte B3 has offset 0 and B0 offset 3, so offset*8 + cnt is just {offset, cnt}.
    // Scanning upward from B0 lets the most significant non-zero byte win.
    always_comb begin
        cnt_comb = LZC_ALLZERO;
        for (int b = 0; b < LZC_BYTES; b++) begin
            if (!byte_zero[b]) begin
                cnt_comb = {1'b0, 2'(3 - b), byte_cnt[b]};
            end
        end
    end

    // Hold path is selected by in_valid so X on data cannot reach z when idle.
    always_comb begin
        z_d         = z_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            z_d = cnt_comb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign z         = z_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_lzc_top.sv
// tb_lzc_top: scoreboard bench for lzc_top. Expected counts come from lzc_ref
// and are queued when a valid word is driven, then popped one cycle later.
module tb_lzc_top;
    import lzc_pkg::*;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b1;
    logic [31:0] data     = 32'h0000_0001;
    logic        out_valid;
    logic [5:0]  z;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [5:0]  exp_q[$];
    string       tag_q[$];
    logic        pending  = 1'b0;
    logic [5:0]  z_hold   = 6'd0;

    lzc_top #(
        .WIDTH (32),
        .ZW    (6)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .data      (data),
        .out_valid (out_valid),
        .z         (z)
    );

    always #5 clk = ~clk;

    // Golden model: plain priority loop from bit 31 down.
    function automatic logic [5:0] lzc_ref(input logic [31:0] d);
        logic [5:0] r;
        logic       found;
        r     = 6'd32;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && d[i]) begin
                r     = 6'(31 - i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check the result of the previously driven word, then drive the next one.
    task automatic step(input logic v, input logic [31:0] d, input string tag);
        logic [5:0] e;
        string      t;
        @(posedge clk);
        #1;
        if (pending) begin
            if (exp_q.size() == 0) begin
                check_eq("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check_eq({t, "_valid"}, {31'd0, out_valid}, 32'd1);
                check_eq(t, {26'd0, z}, {26'd0, e});
                z_hold = e;
            end
        end else begin
            check_eq("idle_valid", {31'd0, out_valid}, 32'd0);
            check_eq("idle_hold", {26'd0, z}, {26'd0, z_hold});
        end
        in_valid = v;
        data     = d;
        pending  = v;
        if (v) begin
            exp_q.push_back(lzc_ref(d));
            tag_q.push_back(tag);
        end
    endtask

    initial begin
        logic [31:0] w;

        // Reset held with a valid word present: outputs stay cleared.
        #1;
        check_eq("rst_z_t0", {26'd0, z}, 32'd0);
        check_eq("rst_valid_t0", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_z_hold", {26'd0, z}, 32'd0);
            check_eq("rst_valid_hold", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        pending = 1'b1;
        exp_q.push_back(lzc_ref(32'h0000_0001));
        tag_q.push_back("rst_release");

        // Extremes and byte boundaries.
        step(1'b1, 32'h0000_0000, "all_zero");
        step(1'b1, 32'hFFFF_FFFF, "all_ones");
        step(1'b1, 32'h8000_0000, "msb_only");
        step(1'b1, 32'h0000_0001, "lsb_only");
        step(1'b1, 32'h00FF_0000, "b2_full");
        step(1'b1, 32'h0000_8000, "b1_msb");
        step(1'b1, 32'h0000_0080, "b0_msb");
        step(1'b1, 32'h0001_0000, "b2_lsb");
        step(1'b1, 32'h7FFF_FFFF, "msb_clear");

        // Back-to-back stream, then idle with X data: z must hold 32.
        step(1'b1, 32'h0000_0001, "pipe_1");
        step(1'b1, 32'h0000_0100, "pipe_100");
        step(1'b1, 32'h0000_0000, "pipe_0");
        step(1'b0, 32'hxxxx_xxxx, "idle_x");
        step(1'b0, 32'hxxxx_xxxx, "idle_x");
        step(1'b0, 32'h0000_0001, "idle_data");
        check_eq("hold_32", {26'd0, z}, 32'd32);

        // Random words, shifted so every count range gets exercised.
        for (int i = 0; i < 100; i++) begin
            w = $urandom >> $urandom_range(0, 31);
            step(1'b1, w, $sformatf("rand_%0d", i));
        end
        step(1'b0, 32'h0, "drain");

        // Mid-stream reset: result visible, next word in flight, then reset.
        step(1'b1, 32'h0000_0F00, "pre_rst");
        step(1'b1, 32'h0000_00F0, "inflight");
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid_async", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_z_async", {26'd0, z}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("midrst_valid_edge", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_z_edge", {26'd0, z}, 32'd0);
        exp_q.delete();
        tag_q.delete();
        pending  = 1'b0;
        z_hold   = 6'd0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, "post_rst_idle");
        step(1'b1, 32'h0000_0400, "post_rst");
        step(1'b0, 32'h0, "final_drain");
        step(1'b0, 32'h0, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lzc_top.md
# lzc_top

Pipelined 32-bit leading-zero counter. It returns the number of consecutive zero bits in a 32-bit word, counted from the MSB (bit 31) downward. It is a leaf datapath block for normalisation and priority logic. It is checked against a behavioural golden model, `lzc_ref`, which is the same function written as a priority loop with no pipeline.

## Interface
Parameters:
- `WIDTH`, default 32: input word width. Only 32 is supported.
- `ZW`, default 6: count width, equal to clog2(WIDTH)+1, so the value 32 can be represented.

Ports:
- `clk`  in  1: single clock; every register updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: qualifies `data` in the current cycle.
- `data`  in  32: word to be counted.
- `out_valid`  out  1: `z` holds a result produced from a valid input.
- `z`  out  6: leading-zero count, range 0..32.

## Operation
- Output function: `z` = the number of zeros from bit 31 down to the first 1.
  - `z` = 31 − (index of the highest set bit).
  - An all-zero `data` gives `z` = 32 (6'b100000).
  - `z` never exceeds 32. Bit 5 is set only for the all-zero input.
- Internal arrangement:
  - `data` is split into four bytes, B3 = [31:24] down to B0 = [7:0].
  - Each byte gives a 3-bit count and an all-zero flag.
  - A final stage selects the first non-zero byte from B3 downward. Its result is byte_index_offset×8 plus that byte's count, where the offset is 0 for B3 through 3 for B0.
  - If all four flags are set, the result is 32.
- The count logic is purely combinational. Only the output stage is registered.
- `out_valid` is `in_valid` delayed by one cycle.
- `z` is updated only in cycles where `in_valid` = 1. Otherwise it holds its last value.
- `data` is don't-care when `in_valid` = 0. X on `data` must not reach `z` while `in_valid` = 0.

## Timing
- Reset:
  - Asserting `rst_n` low clears `z` to 6'd0 and `out_valid` to 0 immediately, without waiting for a clock edge.
  - Both outputs stay cleared while `rst_n` is low.
  - Release is synchronous: the first valid sample is taken at the first rising edge where `rst_n` = 1.
- Latency: 1 cycle. `data` sampled at edge N with `in_valid` = 1 gives `z`/`out_valid` valid after edge N, and they are read in cycle N+1.
- Throughput: 1 word per cycle, with no stalls and no backpressure.
- Back-to-back valid inputs produce back-to-back results in order.
- Reset mid-stream: any in-flight result is discarded, and `out_valid` reads 0 immediately.
- Critical path: byte count → byte select → add → output register. This must close in one cycle at the target clock.

## Structure
- Package `lzc_pkg`:
  - Constants: `LZC_WIDTH` = 32, `LZC_ZW` = 6, `LZC_BYTES` = 4, `LZC_ALLZERO` = 6'd32.
  - Typedefs: `lzc_word_t` (logic [31:0]) and `lzc_cnt_t` (logic [5:0]).
- Sub-module `lzc8`:
  - Input: 8-bit `d`.
  - Outputs: 3-bit `cnt` (leading zeros, meaningful when `d` is non-zero) and `zero` (d == 0).
  - It is instantiated four times inside `lzc_top`.
- Golden model `lzc_ref`:
  - Verification-only and combinational, with the same `data`/`z` semantics.
  - Implemented as a loop from bit 31 down to bit 0.

## Test plan
- Reset: hold `rst_n` = 0 with `in_valid` = 1 and `data` = 32'h0000_0001 → `z` = 0 and `out_valid` = 0 throughout. Release → `z` = 31 one cycle later.
- Extremes:
  - 32'h0000_0000 → 32
  - 32'hFFFF_FFFF → 0
  - 32'h8000_0000 → 0
  - 32'h0000_0001 → 31
- Byte boundaries:
  - 32'h00FF_0000 → 8
  - 32'h0000_8000 → 16
  - 32'h0000_0080 → 24
  - 32'h0001_0000 → 15
  - 32'h7FFF_FFFF → 1
- Pipeline and hold behaviour: stream 32'h1, 32'h100, 32'h0 on consecutive cycles → `z` = 31, 23, 32 on the following cycles. Then drive `in_valid` = 0 with `data` = X → `z` holds 32 and `out_valid` = 0.
- Random: 100 words from $random compared against `lzc_ref` one cycle later → all 100 match, pass/fail reported for each vector.
- Mid-stream reset: assert `rst_n` low between two valid words → outputs clear asynchronously, and the word in flight produces no `out_valid`.
